// File: rtl/moving_average_pkg.sv
// Shared types and constants for the moving-average filter bank controller.
// Select encodings, required window depths and the select-to-depth map.
package moving_average_pkg;

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    CLEAR  = 2'd1,
    RUN    = 2'd2
  } state_e;

  localparam logic [1:0] SEL_W2   = 2'b00;
  localparam logic [1:0] SEL_W4   = 2'b01;
  localparam logic [1:0] SEL_W8   = 2'b10;
  localparam logic [1:0] SEL_CASC = 2'b11;

  localparam int CNT_W = 4;

  localparam logic [CNT_W-1:0] DEPTH_W2   = 4'd2;
  localparam logic [CNT_W-1:0] DEPTH_W4   = 4'd4;
  localparam logic [CNT_W-1:0] DEPTH_W8   = 4'd8;
  localparam logic [CNT_W-1:0] DEPTH_CASC = 4'd9;

  // Cascade needs one extra sample to prime its 2-tap stage.
  function automatic logic [CNT_W-1:0] depth_of(input logic [1:0] sel);
    logic [CNT_W-1:0] d;
    d = DEPTH_W2;
    case (sel)
      SEL_W2:   d = DEPTH_W2;
      SEL_W4:   d = DEPTH_W4;
      SEL_W8:   d = DEPTH_W8;
      SEL_CASC: d = DEPTH_CASC;
      default:  d = DEPTH_W2;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ma_qual_delay.sv
// Qualifier delay line: one bit per cycle, two read taps, sync flush.
// Tap N returns the bit pushed N cycles earlier.
module ma_qual_delay #(
  parameter int DEPTH = 4,
  parameter int TAP_A = 2,
  parameter int TAP_B = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic flush_i,
  input  logic bit_i,
  output logic tap_a_o,
  output logic tap_b_o
);

  logic [DEPTH-1:0] line_q;
  logic [DEPTH-1:0] line_d;

  always_comb begin
    line_d = '0;
    if (!flush_i) begin
      line_d[0] = bit_i;
      for (int i = 1; i < DEPTH; i++) begin
        line_d[i] = line_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  assign tap_a_o = line_q[TAP_A-1];
  assign tap_b_o = line_q[TAP_B-1];

endmodule

// File: rtl/moving_average_ctrl.sv
// Sequencer for the moving-average bank: select register, clear and
// warm-up, strobe gating and output-strobe qualification.
import moving_average_pkg::*;

module moving_average_ctrl #(
  parameter int CLEAR_CYCLES = 2,
  parameter int LAT_SINGLE   = 2,
  parameter int LAT_CASCADE  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cfg_req_i,
  input  logic [1:0] cfg_sel_i,
  output logic       cfg_ack_o,
  input  logic       strobe_i,
  output logic       filt_strobe_o,
  output logic       filt_clear_o,
  output logic [1:0] filt_sel_o,
  input  logic       filt_strobe_i,
  output logic       out_valid_o,
  output logic       busy_o,
  output logic       drop_o
);

  localparam int QDEPTH =
    (LAT_SINGLE > LAT_CASCADE) ? LAT_SINGLE : LAT_CASCADE;
  localparam int CW =
    (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [CW-1:0] CLR_LAST = CW'(CLEAR_CYCLES - 1);

  state_e           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CW-1:0]    clr_q, clr_d;

  logic [CNT_W-1:0] depth;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;
  logic             fwd;
  logic             drop;
  logic             last_clr;
  logic             qual_bit;
  logic             tap_s;
  logic             tap_c;

  assign depth   = depth_of(sel_q);
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    clr_d    = clr_q;
    accept   = 1'b0;
    fwd      = 1'b0;
    drop     = 1'b0;
    last_clr = 1'b0;
    qual_bit = 1'b0;
    unique case (state_q)
      CLEAR: begin
        drop = strobe_i;
        if (clr_q == CLR_LAST) begin
          last_clr = 1'b1;
          state_d  = WARMUP;
          cnt_d    = '0;
          clr_d    = '0;
        end else begin
          clr_d = clr_q + 1'b1;
        end
      end
      WARMUP, RUN: begin
        if (cfg_req_i) begin
          accept  = 1'b1;
          drop    = strobe_i;
          sel_d   = cfg_sel_i;
          clr_d   = '0;
          state_d = CLEAR;
        end else if (strobe_i) begin
          fwd = 1'b1;
          if (state_q == RUN) begin
            qual_bit = 1'b1;
          end else if (cnt_inc >= depth) begin
            // D-th sample since the clear: window now fully real.
            qual_bit = 1'b1;
            cnt_d    = depth;
            state_d  = RUN;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: begin
        state_d = WARMUP;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WARMUP;
      sel_q   <= SEL_W2;
      cnt_q   <= '0;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      clr_q   <= clr_d;
    end
  end

  ma_qual_delay #(
    .DEPTH (QDEPTH),
    .TAP_A (LAT_SINGLE),
    .TAP_B (LAT_CASCADE)
  ) u_qual (
    .clk     (clk),
    .reset   (reset),
    .flush_i (accept),
    .bit_i   (qual_bit),
    .tap_a_o (tap_s),
    .tap_b_o (tap_c)
  );

  assign filt_strobe_o = fwd;
  assign drop_o        = drop;
  assign cfg_ack_o     = last_clr;
  assign filt_clear_o  = (state_q == CLEAR);
  assign busy_o        = (state_q != RUN);
  assign filt_sel_o    = sel_q;
  assign out_valid_o   = filt_strobe_i &
                         ((sel_q == SEL_CASC) ? tap_c : tap_s);

endmodule

// File: tb/tb_moving_average_ctrl.sv
// Self-checking bench for moving_average_ctrl: directed scenarios plus
// random traffic against a cycle-level behavioural model.
module tb_moving_average_ctrl;

  localparam int CC = 2;
  localparam int LS = 2;
  localparam int LC = 4;

  logic       clk;
  logic       rst;
  logic       cfg_req_i;
  logic [1:0] cfg_sel_i;
  logic       cfg_ack_o;
  logic       strobe_i;
  logic       filt_strobe_o;
  logic       filt_clear_o;
  logic [1:0] filt_sel_o;
  logic       filt_strobe_i;
  logic       out_valid_o;
  logic       busy_o;
  logic       drop_o;

  logic echo;
  logic inj;

  int checks = 0;
  int errors = 0;

  moving_average_ctrl #(
    .CLEAR_CYCLES (CC),
    .LAT_SINGLE   (LS),
    .LAT_CASCADE  (LC)
  ) dut (
    .clk           (clk),
    .reset         (rst),
    .cfg_req_i     (cfg_req_i),
    .cfg_sel_i     (cfg_sel_i),
    .cfg_ack_o     (cfg_ack_o),
    .strobe_i      (strobe_i),
    .filt_strobe_o (filt_strobe_o),
    .filt_clear_o  (filt_clear_o),
    .filt_sel_o    (filt_sel_o),
    .filt_strobe_i (filt_strobe_i),
    .out_valid_o   (out_valid_o),
    .busy_o        (busy_o),
    .drop_o        (drop_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign filt_strobe_i = echo | inj;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t",
               name, got, exp, $time);
    end
  endtask

  function automatic int req_depth(input int s);
    case (s)
      0: return 2;
      1: return 4;
      2: return 8;
      default: return 9;
    endcase
  endfunction

  // ---------------- behavioural model ----------------
  int cyc = 0;
  bit armed = 0;
  int m_sel = 0;
  int m_clear_left = 0;
  int m_samples = 0;
  int flush_cyc = 0;
  bit qh [256];
  bit fso_at [256];

  bit e_acc, e_fs, e_drop, e_ack, e_busy, e_clr, e_qbit, e_valid;

  int n_valid, n_ack, n_clear, n_drop, n_fs;
  bit ack_seen = 0;

  always @(negedge clk) begin
    int lat;
    int d;
    bit clearing;
    clearing = (m_clear_left > 0);
    d        = req_depth(m_sel);
    lat      = (m_sel == 3) ? LC : LS;
    e_clr    = clearing;
    e_acc    = !clearing && cfg_req_i;
    e_fs     = strobe_i && !clearing && !e_acc;
    e_drop   = strobe_i && (clearing || e_acc);
    e_ack    = (m_clear_left == 1);
    e_busy   = clearing || (m_samples < d);
    e_qbit   = e_fs && (m_samples + 1 >= d);
    e_valid  = 1'b0;
    if (filt_strobe_i && (cyc - lat > flush_cyc))
      e_valid = qh[(cyc - lat) % 256];
    if (armed && !rst) begin
      chk("filt_strobe_o", int'(filt_strobe_o), int'(e_fs));
      chk("drop_o", int'(drop_o), int'(e_drop));
      chk("filt_clear_o", int'(filt_clear_o), int'(e_clr));
      chk("cfg_ack_o", int'(cfg_ack_o), int'(e_ack));
      chk("busy_o", int'(busy_o), int'(e_busy));
      chk("out_valid_o", int'(out_valid_o), int'(e_valid));
      chk("filt_sel_o", int'(filt_sel_o), m_sel);
      n_valid += int'(out_valid_o);
      n_ack   += int'(cfg_ack_o);
      n_clear += int'(filt_clear_o);
      n_drop  += int'(drop_o);
      n_fs    += int'(filt_strobe_o);
      if (cfg_ack_o) ack_seen = 1;
    end
    fso_at[cyc % 256] = filt_strobe_o;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_sel        = 0;
      m_clear_left = 0;
      m_samples    = 0;
      flush_cyc    = cyc;
      armed        = 1;
    end else begin
      qh[cyc % 256] = e_qbit;
      if (e_acc) begin
        m_sel        = int'(cfg_sel_i);
        m_clear_left = CC;
        flush_cyc    = cyc;
      end else if (m_clear_left > 0) begin
        m_clear_left--;
        if (m_clear_left == 0) m_samples = 0;
      end
      if (e_fs) m_samples++;
    end
    cyc++;
  end

  // Filter-bank stand-in: return forwarded strobes after the path latency.
  always @(posedge clk) begin
    int lat;
    #1;
    lat  = (filt_sel_o == 2'b11) ? LC : LS;
    echo = (cyc > lat) ? fso_at[(cyc - lat) % 256] : 1'b0;
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic zero_counts();
    n_valid = 0;
    n_ack   = 0;
    n_clear = 0;
    n_drop  = 0;
    n_fs    = 0;
  endtask

  task automatic do_cfg(input logic [1:0] s, input logic strb);
    int k;
    bit got;
    cfg_req_i = 1'b1;
    cfg_sel_i = s;
    strobe_i  = strb;
    k   = 0;
    got = 0;
    while (!got && k < 20) begin
      @(negedge clk);
      if (cfg_ack_o) got = 1;
      k++;
    end
    chk("ack_within_bound", int'(got), 1);
    @(posedge clk);
    #1;
    cfg_req_i = 1'b0;
    strobe_i  = 1'b0;
    ack_seen  = 0;
  endtask

  task automatic strobe_train(input int n, input int period,
                              input bit do_inj, output int first);
    first = 0;
    for (int i = 1; i <= n; i++) begin
      strobe_i = 1'b1;
      tick(1);
      strobe_i = 1'b0;
      tick(1);
      if (do_inj) inj = 1'b1;
      tick(1);
      inj = 1'b0;
      tick(period - 3);
      if (first == 0 && n_valid > 0) first = i;
    end
  endtask

  initial begin
    int first;
    rst       = 1'b1;
    cfg_req_i = 1'b0;
    cfg_sel_i = 2'b00;
    strobe_i  = 1'b0;
    inj       = 1'b0;
    echo      = 1'b0;
    zero_counts();
    tick(3);
    rst = 1'b0;

    // Reset warm-up, window 2
    @(negedge clk);
    chk("rst_busy", int'(busy_o), 1);
    chk("rst_sel", int'(filt_sel_o), 0);
    chk("rst_clear", int'(filt_clear_o), 0);
    chk("rst_valid", int'(out_valid_o), 0);
    tick(1);
    zero_counts();
    strobe_train(1, 4, 0, first);
    chk("warm_busy_after_s1", int'(busy_o), 1);
    strobe_train(2, 4, 0, first);
    chk("warm_busy_after_s3", int'(busy_o), 0);
    tick(2);
    chk("warm_valid_count", n_valid, 2);

    // Reconfigure to window 8 with strobes in accept and clear cycles
    zero_counts();
    do_cfg(2'b10, 1'b1);
    chk("cfg8_clear_cycles", n_clear, 2);
    chk("cfg8_acks", n_ack, 1);
    chk("cfg8_drops", n_drop, 3);
    chk("cfg8_fwd", n_fs, 0);
    chk("cfg8_sel", int'(filt_sel_o), 2);
    zero_counts();
    strobe_train(10, 4, 0, first);
    chk("cfg8_first_valid", first, 8);
    chk("cfg8_valid_count", n_valid, 3);

    // Cascade with injected early strobes
    do_cfg(2'b11, 1'b0);
    zero_counts();
    strobe_train(12, 6, 1, first);
    chk("casc_first_valid", first, 9);
    chk("casc_valid_count", n_valid, 4);

    // Held request, then repeated same-select request
    zero_counts();
    do_cfg(2'b11, 1'b0);
    tick(6);
    chk("held_acks", n_ack, 1);
    chk("held_clears", n_clear, 2);
    zero_counts();
    do_cfg(2'b11, 1'b0);
    chk("same_sel_clears", n_clear, 2);
    chk("same_sel_busy", int'(busy_o), 1);

    // Reset during warm-up of window 8 at count 5
    do_cfg(2'b10, 1'b0);
    for (int i = 0; i < 5; i++) begin
      strobe_i = 1'b1;
      tick(1);
      strobe_i = 1'b0;
      tick(1);
    end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_sel", int'(filt_sel_o), 0);
    chk("midrst_busy", int'(busy_o), 1);
    chk("midrst_clear", int'(filt_clear_o), 0);
    chk("midrst_valid", int'(out_valid_o), 0);
    tick(1);
    for (int i = 0; i < 2; i++) begin
      strobe_i = 1'b1;
      tick(1);
      strobe_i = 1'b0;
      tick(1);
    end
    chk("midrst_busy_after2", int'(busy_o), 0);

    // Random traffic against the model
    ack_seen = 0;
    for (int i = 0; i < 4000; i++) begin
      strobe_i = ($urandom % 2) == 0;
      inj      = ($urandom % 16) == 0;
      rst      = ($urandom % 400) == 0;
      if (rst) begin
        cfg_req_i = 1'b0;
        ack_seen  = 0;
      end else if (cfg_req_i && ack_seen) begin
        cfg_req_i = 1'b0;
        ack_seen  = 0;
      end else if (!cfg_req_i && ($urandom % 30) == 0) begin
        cfg_req_i = 1'b1;
        cfg_sel_i = 2'($urandom % 4);
        ack_seen  = 0;
      end
      tick(1);
    end
    rst       = 1'b0;
    cfg_req_i = 1'b0;
    strobe_i  = 1'b0;
    inj       = 1'b0;
    tick(4);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
